game_reset_sequencer: RTL and testbench

GAME_RESET_SEQUENCER -- requirements
Module: game_reset_sequencer

---
 rtl/pong_ctrl_pkg.sv | 27 ++
 rtl/edge_det.sv | 22 ++
 rtl/game_reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_game_reset_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_ctrl_pkg.sv
// Shared types and constants for the pong game-select / chip-reset controller.
package pong_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_e;

    localparam int NUM_GAMES = 6;

    typedef logic [2:0] game_t;

    localparam game_t GAME_TENNIS   = 3'd0;
    localparam game_t GAME_SOCCER   = 3'd1;
    localparam game_t GAME_SQUASH   = 3'd2;
    localparam game_t GAME_PRACTICE = 3'd3;
    localparam game_t GAME_RIFLE1   = 3'd4;
    localparam game_t GAME_RIFLE2   = 3'd5;

    // "Next game" key steps through the six games and wraps after rifle2.
    function automatic game_t next_game(input game_t g);
        return (g == GAME_RIFLE2) ? GAME_TENNIS : game_t'(g + 3'd1);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered edge detector: compares each input bit with its value one cycle earlier.
module edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] prev_q;

    // Always tracks the input, so it also holds the live value throughout reset
    // and the first cycle after reset cannot report a spurious edge.
    always_ff @(posedge clk) begin
        prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;
    assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/game_reset_sequencer.sv
// Sequences game selection and the game chip reset: waits for vsync, then holds
// the chip in reset for RESET_CYCLES with the new game pins applied.
module game_reset_sequencer
    import pong_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 128,
    parameter int DEFAULT_GAME = 1,
    parameter int VS_TIMEOUT   = 2**20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_gamesel,
    input  logic       i_key_reset,
    input  logic       i_host_reset_n,
    input  logic       i_vsync,
    output logic [5:0] o_game_n,
    output logic       o_chip_reset,
    output logic       o_busy
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int VW = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [VW-1:0] VS_LAST   = VW'(VS_TIMEOUT - 1);
    localparam game_t         DEF_GAME  = game_t'(DEFAULT_GAME);

    seq_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [VW-1:0] vs_cnt_q, vs_cnt_d;
    game_t         game_q, game_d;
    game_t         pend_q, pend_d;

    logic [6:0] gs_rise, gs_fall;
    logic [1:0] rst_rise, rst_fall;
    logic       vs_rise, vs_fall;
    logic       unused_edges;

    edge_det #(.WIDTH(7)) u_gs_edge (
        .clk(clk), .d_i(i_gamesel), .rise_o(gs_rise), .fall_o(gs_fall)
    );
    edge_det #(.WIDTH(2)) u_rst_edge (
        .clk(clk), .d_i({i_key_reset, i_host_reset_n}), .rise_o(rst_rise), .fall_o(rst_fall)
    );
    edge_det #(.WIDTH(1)) u_vs_edge (
        .clk(clk), .d_i(i_vsync), .rise_o(vs_rise), .fall_o(vs_fall)
    );

    assign unused_edges = ^{gs_fall, rst_rise[0], rst_fall[1], vs_fall};

    logic  req;
    logic  direct_hit;
    game_t sel_game;

    assign req = (|gs_rise) | rst_rise[1] | rst_fall[0];

    // Lowest direct key wins; "next" only counts when no direct key fired.
    always_comb begin
        direct_hit = 1'b0;
        sel_game   = pend_q;
        for (int i = NUM_GAMES - 1; i >= 0; i--) begin
            if (gs_rise[i]) begin
                sel_game   = game_t'(i);
                direct_hit = 1'b1;
            end
        end
        if (!direct_hit && gs_rise[6]) begin
            sel_game = next_game(pend_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        vs_cnt_d   = vs_cnt_q;
        game_d     = game_q;
        pend_d     = pend_q;
        case (state_q)
            ST_IDLE: begin
                vs_cnt_d = '0;
                if (req) begin
                    pend_d  = sel_game;
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (req) begin
                    pend_d = sel_game;
                end
                vs_cnt_d = vs_cnt_q + VW'(1);
                if (vs_rise || vs_cnt_q == VS_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    game_d     = pend_d;
                end
            end
            ST_HOLD: begin
                if (req) begin
                    pend_d     = sel_game;
                    game_d     = sel_game;
                    hold_cnt_d = '0;
                end else if (!i_host_reset_n) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                vs_cnt_d = '0;
                if (req) begin
                    pend_d  = sel_game;
                    state_d = ST_WAIT_VS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            vs_cnt_q   <= '0;
            game_q     <= DEF_GAME;
            pend_q     <= DEF_GAME;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            vs_cnt_q   <= vs_cnt_d;
            game_q     <= game_d;
            pend_q     <= pend_d;
        end
    end

    assign o_game_n     = ~(6'b000001 << game_q);
    assign o_chip_reset = (state_q == ST_HOLD);
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_game_reset_sequencer.sv
// Directed and randomized checks of game selection and chip-reset sequencing.
module tb_game_reset_sequencer;

    localparam int RC = 8;
    localparam int DG = 1;
    localparam int VT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] i_gamesel;
    logic       i_key_reset;
    logic       i_host_reset_n;
    logic       i_vsync;
    logic [5:0] o_game_n;
    logic       o_chip_reset;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;
    int model_game;

    game_reset_sequencer #(
        .RESET_CYCLES(RC), .DEFAULT_GAME(DG), .VS_TIMEOUT(VT)
    ) dut (
        .clk(clk), .reset(reset), .i_gamesel(i_gamesel), .i_key_reset(i_key_reset),
        .i_host_reset_n(i_host_reset_n), .i_vsync(i_vsync), .o_game_n(o_game_n),
        .o_chip_reset(o_chip_reset), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] gn_of(input int g);
        logic [5:0] v;
        v = 6'b111111;
        v[g] = 1'b0;
        return v;
    endfunction

    // Game chosen by a request made from an all-low key state.
    function automatic int resolve(input int cur, input logic [6:0] gs);
        for (int i = 0; i < 6; i++) if (gs[i]) return i;
        if (gs[6]) return (cur + 1) % 6;
        return cur;
    endfunction

    task automatic req_pulse(input logic [6:0] gs, input bit key, input bit host);
        i_gamesel      = gs;
        i_key_reset    = key;
        i_host_reset_n = ~host;
        tick();
        i_gamesel      = '0;
        i_key_reset    = 1'b0;
        i_host_reset_n = 1'b1;
    endtask

    // Called on the first cycle after the request; optionally pulses vsync d cycles after it.
    task automatic wait_to_hold(input bit use_vs, input int d, input logic [5:0] exp_gn, input string tag);
        int lat = 1;
        int bad = 0;
        while (o_chip_reset !== 1'b1 && lat < 200) begin
            if (o_game_n !== gn_of(model_game) || o_busy !== 1'b1) bad++;
            i_vsync = (use_vs && lat == d);
            tick();
            lat++;
        end
        i_vsync = 1'b0;
        check({tag, "_lat"}, lat, use_vs ? d + 1 : VT + 1);
        check({tag, "_wait"}, bad, 0);
        check({tag, "_gn0"}, o_game_n, exp_gn);
    endtask

    // Called on the first HOLD cycle; returns on the RELEASE cycle.
    task automatic measure_hold(input logic [5:0] exp_gn, input string tag);
        int n = 0;
        int bad = 0;
        while (o_chip_reset === 1'b1 && n < 300) begin
            if (o_game_n !== exp_gn || o_busy !== 1'b1) bad++;
            n++;
            tick();
        end
        check({tag, "_len"}, n, RC);
        check({tag, "_gn"}, bad, 0);
        check({tag, "_rel"}, {o_busy, o_chip_reset, o_game_n}, {2'b10, exp_gn});
    endtask

    task automatic do_seq(input logic [6:0] gs, input bit key, input bit host, input bit use_vs,
                          input int d, input bit chain, input string tag);
        int exp_game;
        exp_game = resolve(model_game, gs);
        req_pulse(gs, key, host);
        wait_to_hold(use_vs, d, gn_of(exp_game), tag);
        model_game = exp_game;
        measure_hold(gn_of(exp_game), tag);
        if (!chain) begin
            tick();
            check({tag, "_idle"}, {o_busy, o_chip_reset, o_game_n}, {2'b00, gn_of(exp_game)});
        end
    endtask

    initial begin
        int a, b, n, bad, kind;
        logic [6:0] gs1, gs2;

        reset          = 1'b1;
        i_gamesel      = '0;
        i_key_reset    = 1'b0;
        i_host_reset_n = 1'b1;
        i_vsync        = 1'b0;
        model_game     = DG;
        repeat (3) tick();
        check("rst_chip", o_chip_reset, 1);
        check("rst_busy", o_busy, 1);
        check("rst_game", o_game_n, gn_of(DG));

        // Power-on hold runs without any vsync.
        reset = 1'b0;
        measure_hold(gn_of(DG), "poweron");
        tick();
        check("poweron_idle", o_busy, 0);

        do_seq(7'b0000100, 0, 0, 1, 10, 0, "direct");
        do_seq(7'b0100000, 0, 0, 1, 2, 0, "to5");
        do_seq(7'b1000000, 0, 0, 1, 2, 0, "wrap");
        do_seq(7'b1001010, 0, 0, 1, 2, 0, "prio");
        do_seq(7'b0000000, 1, 0, 0, 0, 0, "timeout");
        do_seq(7'b0000000, 0, 1, 1, 5, 0, "host");

        // Request landing in RELEASE chains straight into a new sequence.
        do_seq(7'b0001000, 0, 0, 1, 4, 1, "chain_a");
        do_seq(7'b1000000, 0, 0, 1, 3, 0, "chain_b");

        // Restart: the second request lands as the counter would step to 5.
        a   = $urandom_range(0, 5);
        gs1 = 7'b0000001 << a;
        gs2 = 7'($urandom_range(1, 127));
        b   = resolve(a, gs2);
        req_pulse(gs1, 0, 0);
        wait_to_hold(1, 3, gn_of(a), "restart_in");
        model_game = a;
        n   = 0;
        bad = 0;
        while (o_chip_reset === 1'b1 && n < 300) begin
            if (o_game_n !== ((n < 5) ? gn_of(a) : gn_of(b))) bad++;
            i_gamesel = (n == 4) ? gs2 : 7'b0;
            n++;
            tick();
        end
        i_gamesel = '0;
        check("restart_len", n, 5 + RC);
        check("restart_gn", bad, 0);
        model_game = b;
        tick();
        check("restart_idle", {o_busy, o_game_n}, {1'b0, gn_of(b)});

        for (int k = 0; k < 6; k++) begin
            kind = $urandom_range(0, 2);
            gs1  = (kind == 0) ? 7'($urandom_range(1, 127)) : 7'b0;
            do_seq(gs1, kind == 1, kind == 2, 1'($urandom_range(0, 1)), $urandom_range(1, 40), 0, "rand");
        end

        // Reset in WAIT_VS aborts the sequence and the request is not replayed.
        req_pulse(7'b0001000, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midrst_state", {o_busy, o_chip_reset, o_game_n}, {2'b11, gn_of(DG)});
        reset      = 1'b0;
        model_game = DG;
        measure_hold(gn_of(DG), "midrst");
        tick();
        bad = 0;
        repeat (VT + 16) begin
            if (o_busy !== 1'b0 || o_game_n !== gn_of(DG)) bad++;
            tick();
        end
        check("midrst_noreplay", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
